// File: rtl/gate_pkg.sv
// Shared op encodings for the multi-input gate pipeline.
// Imported by gate_reduce and multi_gate_pipe.
package gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS0 = 3'd6;
  localparam logic [OP_W-1:0] OP_INV0  = 3'd7;

endpackage

// File: rtl/gate_reduce.sv
// Combinational bitwise gate applied across NUM_IN operands.
// Operand k sits at operands[k*WIDTH +: WIDTH].
module gate_reduce
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic [OP_W-1:0]         op,
  input  logic [NUM_IN*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] op0;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & operands[k*WIDTH +: WIDTH];
      or_r  = or_r  | operands[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
    end
  end

  assign op0 = operands[WIDTH-1:0];

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:   result = and_r;
      OP_OR:    result = or_r;
      OP_XOR:   result = xor_r;
      OP_NAND:  result = ~and_r;
      OP_NOR:   result = ~or_r;
      OP_XNOR:  result = ~xor_r;
      OP_PASS0: result = op0;
      OP_INV0:  result = ~op0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/multi_gate_pipe.sv
// Two-stage valid/ready gate pipeline with a saturating
// count of results accepted downstream.
module multi_gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        res_cnt
);

  logic                    s1_valid;
  logic [NUM_IN*WIDTH-1:0] s1_data;
  logic [OP_W-1:0]         s1_op;
  logic                    s2_valid;
  logic [WIDTH-1:0]        s2_data;
  logic                    s2_zero;
  logic [WIDTH-1:0]        gate_res;
  logic                    s2_adv;
  logic                    fire;

  assign s2_adv = !s2_valid || out_ready;
  assign fire   = s2_valid && out_ready;

  // Held low during reset so nothing is offered an accept.
  assign in_ready = rst_n && (!s1_valid || s2_adv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_op   <= in_op;
      end
    end
  end

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .op       (s1_op),
    .operands (s1_data),
    .result   (gate_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= gate_res;
        s2_zero <= (gate_res == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (cnt_clr) begin
      res_cnt <= '0;
    end else if (fire && (res_cnt != '1)) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_valid && s2_zero;

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Directed and random checks of multi_gate_pipe against a
// per-bit reference model via an in-order scoreboard.
module tb_multi_gate_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_op;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, out_zero;
  logic [7:0]  out_data;
  logic [15:0] res_cnt;

  logic        in_ready4, out_valid4, out_zero4;
  logic [7:0]  out_data4;
  logic [3:0]  res_cnt4;

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  multi_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .cnt_clr(cnt_clr), .res_cnt(res_cnt)
  );

  multi_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_zero(out_zero4),
    .cnt_clr(cnt_clr), .res_cnt(res_cnt4)
  );

  function automatic logic [7:0] model(
    input logic [2:0] op, input logic [31:0] d);
    logic [7:0] r;
    int n;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      for (int k = 0; k < 4; k++) n += int'(d[k*8+b]);
      case (op)
        3'd0: r[b] = (n == 4);
        3'd1: r[b] = (n != 0);
        3'd2: r[b] = (n % 2 == 1);
        3'd3: r[b] = (n != 4);
        3'd4: r[b] = (n == 0);
        3'd5: r[b] = (n % 2 == 0);
        3'd6: r[b] = d[b];
        default: r[b] = ~d[b];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
        chk("out_zero", 32'(out_zero), 32'(e == 8'h00));
      end
    end
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1)
      sb.push_back(model(in_op, in_data));
  end

  logic [7:0]  tab [8];
  logic [31:0] bd  [6];
  logic [2:0]  bo  [6];
  logic [7:0]  exp0;
  int          sent;
  bit          acc;

  initial begin
    tab = '{8'h80, 8'hFF, 8'h69, 8'h7F,
            8'h00, 8'h96, 8'hFF, 8'h00};
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = {8'hF0, 8'hCC, 8'hAA, 8'hFF};
    in_op     = 3'd0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // Reset / idle
    repeat (5) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res_cnt", 32'(res_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    step();

    // All ops, one per cycle, with latency checks
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 8);
      in_op    = 3'(i);
      in_data  = {8'hF0, 8'hCC, 8'hAA, 8'hFF};
      step();
      if (i == 0) chk("lat_first_edge", 32'(out_valid), 32'd0);
      if (i >= 1) begin
        chk("op_valid", 32'(out_valid), 32'd1);
        chk($sformatf("op%0d", i - 1), 32'(out_data),
            32'(tab[i-1]));
      end
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("ops_cnt", 32'(res_cnt), 32'd8);

    // Back-pressure
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bd[i] = $urandom;
      bo[i] = 3'($urandom_range(0, 7));
    end
    exp0 = model(bo[0], bd[0]);
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c >= 6);
      in_valid  = (sent < 6);
      in_data   = bd[sent < 6 ? sent : 0];
      in_op     = bo[sent < 6 ? sent : 0];
      #1;
      acc = in_valid && in_ready;
      if (c >= 2 && c <= 5) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'(exp0));
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_cnt", 32'(res_cnt), 32'd6);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_op    = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("sat_cnt4", 32'(res_cnt4), 32'd15);
    chk("sat_cnt16", 32'(res_cnt), 32'd20);
    in_valid = 1'b1;
    repeat (3) step();
    chk("clr_fire_valid", 32'(out_valid && out_ready), 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt4", 32'(res_cnt4), 32'd0);
    chk("clr_cnt16", 32'(res_cnt), 32'd0);
    repeat (3) step();

    // Reset with bundles in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    chk("mid_loaded", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    repeat (2) step();
    sb.delete();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_no_out", 32'(out_valid), 32'd0);
    end
    chk("mid_cnt", 32'(res_cnt), 32'd0);

    // Random valid/ready traffic
    hs   = 0;
    sent = 0;
    in_data = $urandom;
    in_op   = 3'($urandom_range(0, 7));
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_data = $urandom;
        in_op   = 3'($urandom_range(0, 7));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    step();
    chk("rnd_sent", 32'(sent), 32'd1000);
    chk("rnd_drained", 32'(sb.size()), 32'd0);
    chk("rnd_cnt", 32'(res_cnt), 32'(hs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
